// File: rtl/dcache_responder_if.sv
// Bus bundle for dcache_responder: CPU load/store port plus the line-wide
// backing-memory request/ack channel. The cache sits on the slave side.
interface dcache_responder_if #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned MEM_AW    = 32
);
    // CPU side
    logic [31:0]           addr_i;
    logic [31:0]           data_i;
    logic                  MemRead_i;
    logic                  MemWrite_i;
    logic [31:0]           data_o;
    logic                  stall_o;
    // Backing memory side
    logic                  mem_req_o;
    logic                  mem_write_o;
    logic [MEM_AW-1:0]     mem_addr_o;
    logic [LINE_BITS-1:0]  mem_data_o;
    logic [LINE_BITS-1:0]  mem_data_i;
    logic                  mem_ack_i;

    modport slave (
        input  addr_i, data_i, MemRead_i, MemWrite_i, mem_data_i, mem_ack_i,
        output data_o, stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output addr_i, data_i, MemRead_i, MemWrite_i, mem_data_i, mem_ack_i,
        input  data_o, stall_o, mem_req_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Hits complete combinationally in the same cycle; a miss stalls the CPU
// while a dirty victim is written back (WB), the line is read (RD) and
// installed (FILL), after which the held request re-evaluates as a hit.
module dcache_responder #(
    parameter int unsigned LINES     = 32,
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned MEM_AW    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dcache_responder_if.slave bus
);
    localparam int unsigned IW    = $clog2(LINES);
    localparam int unsigned WORDS = LINE_BITS / 32;
    localparam int unsigned WW    = $clog2(WORDS);
    localparam int unsigned OW    = WW + 2;
    localparam int unsigned TW    = 32 - OW - IW;

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_FILL} state_t;

    state_t            state_q;
    state_t            state_d;

    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TW-1:0]     tag_arr  [LINES];
    line_t             data_arr [LINES];
    line_t             line_buf;
    logic [31:0]       data_q;

    logic [TW-1:0]     tag;
    logic [IW-1:0]     index;
    logic [WW-1:0]     word;
    logic [1:0]        unused_byte_offset;

    logic              access;
    logic              is_load;
    logic              hit;
    logic              load_hit;
    logic              store_hit;
    logic [31:0]       victim_addr;
    logic [31:0]       fill_addr;

    assign tag                = bus.addr_i[31 -: TW];
    assign index              = bus.addr_i[OW +: IW];
    assign word               = bus.addr_i[2 +: WW];
    assign unused_byte_offset = bus.addr_i[1:0];

    // A simultaneous read+write is handled as a store.
    assign access    = bus.MemRead_i | bus.MemWrite_i;
    assign is_load   = bus.MemRead_i & ~bus.MemWrite_i;
    assign hit       = valid[index] & (tag_arr[index] == tag);
    assign load_hit  = (state_q == S_IDLE) & is_load & hit;
    assign store_hit = (state_q == S_IDLE) & bus.MemWrite_i & hit;

    assign victim_addr = {tag_arr[index], index, {OW{1'b0}}};
    assign fill_addr   = {tag, index, {OW{1'b0}}};

    // Load data is live on a hit and otherwise holds the last loaded word.
    assign bus.data_o  = load_hit ? data_arr[index][word] : data_q;

    // Reset gates stall so an aborted miss releases the pipeline immediately.
    assign bus.stall_o = ~rst_i & ((state_q != S_IDLE) | (access & ~hit));

    // Miss sequencing: victim write-back only when the resident line is dirty.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (access && !hit) begin
                    state_d = (valid[index] && dirty[index]) ? S_WB : S_RD;
                end
            end
            S_WB: begin
                if (bus.mem_ack_i) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                if (bus.mem_ack_i) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory request outputs, held stable for the whole WB/RD phase.
    always_comb begin
        bus.mem_req_o   = 1'b0;
        bus.mem_write_o = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;
        unique case (state_q)
            S_WB: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_write_o = 1'b1;
                bus.mem_addr_o  = MEM_AW'(victim_addr);
                bus.mem_data_o  = data_arr[index];
            end
            S_RD: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_addr_o  = MEM_AW'(fill_addr);
            end
            default: begin
            end
        endcase
    end

    // State, line status bits and held load data; reset invalidates all lines.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid   <= '0;
            dirty   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_hit) begin
                data_q <= data_arr[index][word];
            end
            if (store_hit) begin
                dirty[index] <= 1'b1;
            end
            if (state_q == S_FILL) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end
        end
    end

    // Tag/data storage and the refill buffer carry no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == S_RD && bus.mem_ack_i) begin
            line_buf <= bus.mem_data_i;
        end
        if (state_q == S_FILL) begin
            tag_arr[index]  <= tag;
            data_arr[index] <= line_buf;
        end
        if (store_hit) begin
            data_arr[index][word] <= bus.data_i;
        end
    end
endmodule
